// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 64-bit single-port RAM between instruction fetch and load/store.
// Handles byte-lane alignment, load extension and one outstanding transaction with valid/ready responses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter bit          IF_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [31:0]       if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic              ls_req_wen,
  input  logic [1:0]        ls_req_size,
  input  logic              ls_req_unsigned,
  input  logic [63:0]       ls_req_wdata,
  output logic              ls_rsp_valid,
  input  logic              ls_rsp_ready,
  output logic [63:0]       ls_rsp_rdata,
  output logic              ls_rsp_err,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_be,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        last_if_q, last_if_d;
  logic        own_ls_q, own_ls_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        wen_q, wen_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic        rsp_err_q, rsp_err_d;
  logic [63:0] rsp_data_q, rsp_data_d;

  logic              idle, gnt_if, gnt_ls, accept, mis, go, rsp_hs;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic              sel_wen, sel_uns;
  logic [63:0]       sel_wdata;
  logic [7:0]        be_base;
  logic [63:0]       rd_shift, load_res;

  // Grants are suppressed while reset is asserted so nothing is issued to memory then.
  assign idle   = rst && (state_q == S_IDLE);
  assign gnt_if = idle && if_req_valid && (!ls_req_valid || !last_if_q);
  assign gnt_ls = idle && ls_req_valid && (!if_req_valid || last_if_q);
  assign accept = gnt_if || gnt_ls;
  assign go     = accept && !mis;
  assign rsp_hs = (state_q == S_RESP) && (own_ls_q ? ls_rsp_ready : if_rsp_ready);

  always_comb begin
    sel_addr  = gnt_ls ? ls_req_addr : if_req_addr;
    sel_size  = gnt_ls ? ls_req_size : 2'd2;
    sel_wen   = gnt_ls && ls_req_wen;
    sel_uns   = gnt_ls ? ls_req_unsigned : 1'b1;
    sel_wdata = gnt_ls ? ls_req_wdata : 64'h0;
  end

  always_comb begin
    mis     = 1'b0;
    be_base = 8'h01;
    case (sel_size)
      2'd0: begin mis = 1'b0;             be_base = 8'h01; end
      2'd1: begin mis = sel_addr[0];      be_base = 8'h03; end
      2'd2: begin mis = |sel_addr[1:0];   be_base = 8'h0F; end
      default: begin mis = |sel_addr[2:0]; be_base = 8'hFF; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = mis ? S_RESP : S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_req_ready = gnt_if;
    ls_req_ready = gnt_ls;
    mem_en       = go;
    mem_wen      = go && sel_wen;
    mem_addr     = '0;
    mem_be       = 8'h00;
    mem_wdata    = 64'h0;
    if (go) begin
      mem_addr  = {sel_addr[ADDR_W-1:3], 3'b000};
      mem_be    = be_base << sel_addr[2:0];
      mem_wdata = sel_wdata << {sel_addr[2:0], 3'b000};
    end
  end

  // Load realignment: bring the addressed byte to lane 0, then trim and extend.
  assign rd_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_res = 64'h0;
    if (!own_ls_q) begin
      load_res = {32'h0, off_q[2] ? mem_rdata[63:32] : mem_rdata[31:0]};
    end else if (!wen_q) begin
      case (size_q)
        2'd0:    load_res = {{56{!uns_q && rd_shift[7]}},  rd_shift[7:0]};
        2'd1:    load_res = {{48{!uns_q && rd_shift[15]}}, rd_shift[15:0]};
        2'd2:    load_res = {{32{!uns_q && rd_shift[31]}}, rd_shift[31:0]};
        default: load_res = rd_shift;
      endcase
    end
  end

  always_comb begin
    last_if_d  = last_if_q;
    own_ls_d   = own_ls_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wen_d      = wen_q;
    rsp_vld_d  = rsp_vld_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    if (accept) begin
      last_if_d = gnt_if;
      own_ls_d  = gnt_ls;
      off_d     = sel_addr[2:0];
      size_d    = sel_size;
      uns_d     = sel_uns;
      wen_d     = sel_wen;
      if (mis) begin
        rsp_vld_d  = 1'b1;
        rsp_err_d  = 1'b1;
        rsp_data_d = 64'h0;
      end
    end
    if (state_q == S_WAIT) begin
      rsp_vld_d  = 1'b1;
      rsp_err_d  = 1'b0;
      rsp_data_d = load_res;
    end
    if (rsp_hs) begin
      rsp_vld_d  = 1'b0;
      rsp_err_d  = 1'b0;
      rsp_data_d = 64'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_if_q  <= ~IF_FIRST;
      own_ls_q   <= 1'b0;
      off_q      <= 3'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      wen_q      <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= 64'h0;
    end else begin
      last_if_q  <= last_if_d;
      own_ls_q   <= own_ls_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wen_q      <= wen_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // One shared response register, steered to its owner; the other side reads zero.
  assign if_rsp_valid = rsp_vld_q && !own_ls_q;
  assign if_rsp_err   = rsp_err_q && !own_ls_q;
  assign if_rsp_data  = own_ls_q ? 32'h0 : rsp_data_q[31:0];
  assign ls_rsp_valid = rsp_vld_q && own_ls_q;
  assign ls_rsp_err   = rsp_err_q && own_ls_q;
  assign ls_rsp_rdata = own_ls_q ? rsp_data_q : 64'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed plan steps followed by random traffic,
// checked against a byte-addressed memory model and a round-robin winner model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [31:0] if_req_addr = '0;
  logic        if_rsp_valid, if_rsp_ready = 1'b0, if_rsp_err;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid = 1'b0, ls_req_ready;
  logic [31:0] ls_req_addr = '0;
  logic        ls_req_wen = 1'b0, ls_req_unsigned = 1'b0;
  logic [1:0]  ls_req_size = '0;
  logic [63:0] ls_req_wdata = '0;
  logic        ls_rsp_valid, ls_rsp_ready = 1'b0, ls_rsp_err;
  logic [63:0] ls_rsp_rdata;
  logic        mem_en, mem_wen;
  logic [31:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata, mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .IF_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_wen(ls_req_wen), .ls_req_size(ls_req_size), .ls_req_unsigned(ls_req_unsigned),
    .ls_req_wdata(ls_req_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_rdata(ls_rsp_rdata),
    .ls_rsp_err(ls_rsp_err),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        v;
    logic [31:0] addr;
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wd;
  } req_t;

  typedef struct {
    bit          won_ls;
    logic        en, wen;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wd;
    logic [63:0] rdata;
    logic        err;
  } obs_t;

  logic [63:0] ram [16];      // word-wide RAM behind the DUT memory port
  logic [7:0]  ref_mem [128]; // reference byte view of the same contents
  bit          last_if;       // reference: IF took the most recent grant
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [63:0] w);
    ram[idx] = w;
    for (int b = 0; b < 8; b++) ref_mem[idx*8 + b] = w[8*b +: 8];
  endtask

  // Advance one clock; the RAM acts on what the DUT drove during the cycle just ended.
  task automatic tick();
    logic en, wen;
    logic [31:0] a;
    logic [7:0]  be;
    logic [63:0] wd;
    en = mem_en; wen = mem_wen; a = mem_addr; be = mem_be; wd = mem_wdata;
    @(posedge clk); #1;
    if (en && wen)
      for (int b = 0; b < 8; b++) if (be[b]) ram[a[6:3]][8*b +: 8] = wd[8*b +: 8];
    mem_rdata = (en && !wen) ? ram[a[6:3]] : {$urandom, $urandom};
  endtask

  function automatic logic [63:0] ref_read(input logic [31:0] a, input int n, input logic uns);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a[6:0]) + i];
    if (!uns && n < 8 && v[8*n-1]) for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_txn(input req_t ir, input req_t lr, input int bp, output obs_t o);
    bit w_ls, mis, wen, uns;
    int n;
    logic [31:0] a;
    logic [63:0] wd, exp_data;
    logic [7:0]  be;
    if_req_valid = ir.v; if_req_addr = ir.addr;
    ls_req_valid = lr.v; ls_req_addr = lr.addr; ls_req_wen = lr.wen;
    ls_req_size = lr.size; ls_req_unsigned = lr.uns; ls_req_wdata = lr.wd;
    #1;
    w_ls = (ir.v && lr.v) ? last_if : lr.v;
    a    = w_ls ? lr.addr : ir.addr;
    n    = w_ls ? (1 << lr.size) : 4;
    wen  = w_ls && lr.wen;
    uns  = w_ls ? lr.uns : 1'b1;
    wd   = w_ls ? lr.wd : 64'h0;
    mis  = (int'(a[2:0]) % n) != 0;
    be   = '0;
    if (!mis) for (int i = 0; i < n; i++) be[int'(a[2:0]) + i] = 1'b1;
    o.won_ls = w_ls; o.en = mem_en; o.wen = mem_wen; o.addr = mem_addr;
    o.be = mem_be; o.wd = mem_wdata;
    chk("if_req_ready", {63'h0, if_req_ready}, {63'h0, !w_ls});
    chk("ls_req_ready", {63'h0, ls_req_ready}, {63'h0, w_ls});
    chk("mem_en", {63'h0, mem_en}, {63'h0, !mis});
    chk("mem_wen", {63'h0, mem_wen}, {63'h0, !mis && wen});
    chk("mem_addr", {32'h0, mem_addr}, mis ? 64'h0 : {32'h0, a & ~32'h7});
    chk("mem_be", {56'h0, mem_be}, {56'h0, be});
    chk("mem_wdata", mem_wdata, mis ? 64'h0 : (wd << (8 * int'(a[2:0]))));
    if (mis)        exp_data = '0;
    else if (!w_ls) exp_data = {32'h0, ref_read(a, 4, 1'b1)[31:0]};
    else if (wen) begin
      exp_data = '0;
      for (int i = 0; i < n; i++) ref_mem[int'(a[6:0]) + i] = wd[8*i +: 8];
    end else        exp_data = ref_read(a, n, uns);
    last_if = !w_ls;
    tick();
    // Requester is free to change its inputs once accepted.
    if (w_ls) begin
      ls_req_addr = $urandom; ls_req_size = 2'($urandom % 4); ls_req_wen = 1'($urandom % 2);
      ls_req_unsigned = 1'($urandom % 2); ls_req_wdata = {$urandom, $urandom};
    end else if_req_addr = $urandom;
    if (!mis) begin
      if_rsp_ready = 1'($urandom % 2); ls_rsp_ready = 1'($urandom % 2);
      #1;
      chk("wait_ready", {62'h0, if_req_ready, ls_req_ready}, 64'h0);
      chk("wait_valid", {62'h0, if_rsp_valid, ls_rsp_valid}, 64'h0);
      chk("wait_mem_en", {63'h0, mem_en}, 64'h0);
      tick();
    end
    for (int k = 0; k <= bp; k++) begin
      if (w_ls) begin ls_rsp_ready = (k == bp); if_rsp_ready = 1'($urandom % 2); end
      else      begin if_rsp_ready = (k == bp); ls_rsp_ready = 1'($urandom % 2); end
      #1;
      if (k == 0) begin
        o.rdata = w_ls ? ls_rsp_rdata : {32'h0, if_rsp_data};
        o.err   = w_ls ? ls_rsp_err : if_rsp_err;
      end
      chk("rsp_valid", {63'h0, w_ls ? ls_rsp_valid : if_rsp_valid}, 64'h1);
      chk("rsp_data", w_ls ? ls_rsp_rdata : {32'h0, if_rsp_data}, exp_data);
      chk("rsp_err", {63'h0, w_ls ? ls_rsp_err : if_rsp_err}, {63'h0, mis});
      chk("other_rsp", w_ls ? {30'h0, if_rsp_valid, if_rsp_err, if_rsp_data}
                            : (ls_rsp_rdata | {62'h0, ls_rsp_valid, ls_rsp_err}), 64'h0);
      chk("resp_ready", {62'h0, if_req_ready, ls_req_ready}, 64'h0);
      chk("resp_mem_en", {63'h0, mem_en}, 64'h0);
      tick();
    end
    if_rsp_ready = 1'b0; ls_rsp_ready = 1'b0;
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    #1;
    chk("rsp_drop", {62'h0, if_rsp_valid, ls_rsp_valid}, 64'h0);
  endtask

  function automatic req_t mk_if(input logic [31:0] a);
    req_t r;
    r.v = 1'b1; r.addr = a; r.wen = 1'b0; r.size = 2'd2; r.uns = 1'b0; r.wd = '0;
    return r;
  endfunction

  function automatic req_t mk_ls(input logic [31:0] a, input logic w, input logic [1:0] s,
                                 input logic u, input logic [63:0] d);
    req_t r;
    r.v = 1'b1; r.addr = a; r.wen = w; r.size = s; r.uns = u; r.wd = d;
    return r;
  endfunction

  initial begin
    req_t ir, lr, none;
    obs_t o;
    int   amask;
    none = mk_if(32'h0); none.v = 1'b0;
    for (int i = 0; i < 16; i++) set_word(i, {$urandom, $urandom});
    last_if = 1'b0;
    tick(); tick();
    chk("reset_valids", {60'h0, if_rsp_valid, ls_rsp_valid, if_rsp_err, ls_rsp_err}, 64'h0);
    chk("reset_data", ls_rsp_rdata | {32'h0, if_rsp_data}, 64'h0);
    chk("reset_mem", {30'h0, mem_en, mem_wen, mem_addr} | {56'h0, mem_be} | mem_wdata, 64'h0);
    rst = 1'b1;

    set_word(0, 64'h1234_5678_9ABC_DEF0);
    do_txn(mk_if(32'h8000_0004), none, 0, o);
    chk("if_fetch_en", {63'h0, o.en}, 64'h1);
    chk("if_fetch_addr", {32'h0, o.addr}, 64'h8000_0000);
    chk("if_fetch_be", {56'h0, o.be}, 64'hF0);
    chk("if_fetch_data", o.rdata, 64'h1234_5678);

    do_txn(none, mk_ls(32'h8000_0006, 1'b1, 2'd1, 1'b0, 64'hBEEF), 0, o);
    chk("sh_be", {56'h0, o.be}, 64'hC0);
    chk("sh_wdata", o.wd, 64'hBEEF_0000_0000_0000);
    chk("sh_wen", {63'h0, o.wen}, 64'h1);
    chk("sh_rsp", o.rdata | {63'h0, o.err}, 64'h0);

    set_word(0, 64'h0000_0000_8000_0000);
    do_txn(none, mk_ls(32'h8000_0003, 1'b0, 2'd0, 1'b0, 64'h0), 0, o);
    chk("lb_signed", o.rdata, 64'hFFFF_FFFF_FFFF_FF80);
    do_txn(none, mk_ls(32'h8000_0003, 1'b0, 2'd0, 1'b1, 64'h0), 0, o);
    chk("lb_unsigned", o.rdata, 64'h80);

    do_txn(none, mk_ls(32'h8000_0002, 1'b0, 2'd2, 1'b0, 64'h0), 0, o);
    chk("lw_mis_en", {63'h0, o.en}, 64'h0);
    chk("lw_mis_rsp", {o.rdata[62:0], o.err}, 64'h1);
    do_txn(mk_if(32'h8000_0001), none, 0, o);
    chk("if_mis_rsp", {o.rdata[62:0], o.err}, 64'h1);

    do_txn(none, mk_ls(32'h8000_0010, 1'b0, 2'd3, 1'b0, 64'h0), 1, o);
    do_txn(mk_if(32'h8000_0008), mk_ls(32'h8000_0020, 1'b0, 2'd2, 1'b0, 64'h0), 5, o);
    chk("bp_winner_if", {63'h0, o.won_ls}, 64'h0);
    do_txn(mk_if(32'h8000_0008), mk_ls(32'h8000_0020, 1'b0, 2'd2, 1'b0, 64'h0), 0, o);
    chk("bp_next_ls", {63'h0, o.won_ls}, 64'h1);

    // Reset while the fetch read is in flight: no response may appear afterwards.
    if_req_valid = 1'b1; if_req_addr = 32'h8000_0010;
    #1;
    chk("rst_accept", {63'h0, if_req_ready}, 64'h1);
    tick();
    rst = 1'b0; if_req_valid = 1'b0;
    tick();
    chk("rst_valids", {62'h0, if_rsp_valid, ls_rsp_valid}, 64'h0);
    rst = 1'b1; last_if = 1'b0;
    tick();
    chk("rst_no_rsp", {62'h0, if_rsp_valid, ls_rsp_valid}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      do_txn(mk_if(32'h8000_0018), mk_ls(32'h8000_0028, 1'b0, 2'd1, 1'b1, 64'h0), 0, o);
      chk("alternate", {63'h0, o.won_ls}, {63'h0, 1'(i % 2)});
    end

    for (int r = 0; r < 80; r++) begin
      ir = mk_if(32'h8000_0000 | ($urandom & 32'h7F));
      ir.v = 1'($urandom % 2);
      if ($urandom % 4 != 0) ir.addr[1:0] = 2'b00;
      lr = mk_ls(32'h8000_0000 | ($urandom & 32'h7F), 1'($urandom % 2), 2'($urandom % 4),
                 1'($urandom % 2), {$urandom, $urandom});
      lr.v = 1'($urandom % 2);
      if (!ir.v && !lr.v) lr.v = 1'b1;
      amask = (1 << lr.size) - 1;
      if ($urandom % 4 != 0) lr.addr[2:0] = lr.addr[2:0] & ~3'(amask);
      do_txn(ir, lr, int'($urandom % 3), o);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
